wb_seg7_scanner: RTL and testbench

WB_SEG7_SCANNER -- requirements
Module: wb_seg7_scanner

---
 rtl/wb_seg7_scanner.sv | 170 +++++++++++++++++
 tb/tb_wb_seg7_scanner.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_seg7_scanner.sv
// Wishbone-attached multiplexed 7-segment scanner with binary/hex display modes and per-digit blanking.
// Optional decimal-point output and CTRL[23:16] dp mask when SEG7_DP_EN is defined.
module wb_seg7_scanner #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 200
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  input  logic                  wb_we_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  input  logic [3:0]            wb_sel_i,
  output logic                  wb_ack_o,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic [6:0]            seg_n
`ifdef SEG7_DP_EN
  ,
  output logic                  dp_n
`endif
);

`ifdef SEG7_DP_EN
  localparam logic [31:0] CTRL_WMASK = 32'h00FF_FF03;
`else
  localparam logic [31:0] CTRL_WMASK = 32'h0000_FF03;
`endif

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  // Active-low {a,b,c,d,e,f,g} glyphs
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0:    return 7'b0000001;
      4'h1:    return 7'b1001111;
      4'h2:    return 7'b0010010;
      4'h3:    return 7'b0000110;
      4'h4:    return 7'b1001100;
      4'h5:    return 7'b0100100;
      4'h6:    return 7'b0100000;
      4'h7:    return 7'b0001111;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0000100;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b1100000;
      4'hC:    return 7'b0110001;
      4'hD:    return 7'b1000010;
      4'hE:    return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  logic                  ack_q, ack_d;
  logic [31:0]           dat_q, dat_d;
  logic [31:0]           data_q, data_d;
  logic [31:0]           ctrl_q, ctrl_d;
  logic [15:0]           presc_q, presc_d;
  logic [2:0]            idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  req, wr, tick, blank;
  logic [1:0]            reg_sel;
  logic [31:0]           rd_mux;
  logic [7:0]            blank_mask, dp_mask;
  logic [NUM_DIGITS-1:0] one_hot;
  logic [6:0]            glyph;
  logic                  unused_adr_bits;

  assign unused_adr_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], dp_q};

  // Bus decode, register update and display scan next-state
  always_comb begin
    req     = wb_cyc_i & wb_stb_i & ~ack_q;
    wr      = req & wb_we_i;
    reg_sel = wb_adr_i[3:2];
    ack_d   = req;

    case (reg_sel)
      2'd0:    rd_mux = data_q;
      2'd1:    rd_mux = ctrl_q;
      2'd2:    rd_mux = {29'd0, idx_q};
      default: rd_mux = 32'd0;
    endcase
    if (req) dat_d = rd_mux;
    else     dat_d = 32'd0;

    if (wr && reg_sel == 2'd0) data_d = merge_bytes(data_q, wb_dat_i, wb_sel_i);
    else                       data_d = data_q;
    if (wr && reg_sel == 2'd1) ctrl_d = merge_bytes(ctrl_q, wb_dat_i, wb_sel_i) & CTRL_WMASK;
    else                       ctrl_d = ctrl_q;

    tick = (presc_q == 16'(SCAN_DIV - 1));
    if (tick) presc_d = 16'd0;
    else      presc_d = presc_q + 16'd1;

    // Display decode uses the pre-write register values, so a write on a tick edge shows next tick
    blank_mask = ctrl_q[15:8];
    dp_mask    = ctrl_q[23:16];
    blank      = ~ctrl_q[0] | blank_mask[idx_q];
    for (int k = 0; k < NUM_DIGITS; k++) begin
      one_hot[k] = (idx_q == 3'(k));
    end
    if (ctrl_q[1]) glyph = hex_glyph(data_q[{idx_q, 2'b00} +: 4]);
    else           glyph = hex_glyph({3'b000, data_q[{2'b00, idx_q}]});

    if (tick) begin
      if (idx_q == 3'(NUM_DIGITS - 1)) idx_d = 3'd0;
      else                             idx_d = idx_q + 3'd1;
      if (blank) begin
        an_d  = {NUM_DIGITS{1'b1}};
        seg_d = 7'h7F;
        dp_d  = 1'b1;
      end else begin
        an_d  = ~one_hot;
        seg_d = glyph;
        dp_d  = ~dp_mask[idx_q];
      end
    end else begin
      idx_d = idx_q;
      an_d  = an_q;
      seg_d = seg_q;
      dp_d  = dp_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q   <= 1'b0;
      dat_q   <= 32'd0;
      data_q  <= 32'd0;
      ctrl_q  <= 32'h0000_0001;
      presc_q <= 16'd0;
      idx_q   <= 3'd0;
      an_q    <= {NUM_DIGITS{1'b1}};
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign an_n     = an_q;
  assign seg_n    = seg_q;
`ifdef SEG7_DP_EN
  assign dp_n     = dp_q;
`endif

endmodule

// File: tb/tb_wb_seg7_scanner.sv
// Directed self-checking bench for wb_seg7_scanner (NUM_DIGITS=8, SCAN_DIV=4).
module tb_wb_seg7_scanner;
  localparam int ND = 8;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   adr = 32'd0;
  logic [31:0]   dat_i = 32'd0;
  logic [31:0]   dat_o;
  logic          we = 1'b0, stb = 1'b0, cyc = 1'b0;
  logic [3:0]    sel = 4'd0;
  logic          ack;
  logic [ND-1:0] an_n;
  logic [6:0]    seg_n;
`ifdef SEG7_DP_EN
  logic          dp_n;
`endif

  int checks = 0;
  int errors = 0;
  int n;          // cycles since reset release; a tick lands on every edge where n % SD == 0
  int tick_idx;

  logic [6:0] hex_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  wb_seg7_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
    .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_sel_i(sel), .wb_ack_o(ack),
    .an_n(an_n), .seg_n(seg_n)
`ifdef SEG7_DP_EN
    , .dp_n(dp_n)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  // One request plus one idle cycle; starts and ends on a negedge
  task automatic bus_cycle(input logic wr, input logic [1:0] word, input logic [31:0] wdata,
                           input logic [3:0] be, output logic [31:0] rdata);
    cyc = 1'b1; stb = 1'b1; we = wr; adr = {28'd0, word, 2'b00}; dat_i = wdata; sel = be;
    @(posedge clk); @(negedge clk);
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL bus_ack word=%0d got=%b want=1", word, ack);
    end
    rdata = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic wait_tick();
    for (int k = 0; k < SD; k++) begin
      @(posedge clk); #1;
      if (n % SD == 0) break;
    end
    @(negedge clk);
    tick_idx = ((n / SD) - 1) % ND;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    checks += 4;
    if (ack !== 1'b0)       begin errors++; $display("FAIL rst_ack got=%b want=0", ack); end
    if (dat_o !== 32'd0)    begin errors++; $display("FAIL rst_dat got=%h want=0", dat_o); end
    if (an_n !== 8'hFF)     begin errors++; $display("FAIL rst_an got=%h want=ff", an_n); end
    if (seg_n !== 7'h7F)    begin errors++; $display("FAIL rst_seg got=%h want=7f", seg_n); end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (an_n !== 8'hFF) begin errors++; $display("FAIL pre_tick_an got=%h want=ff", an_n); end
    @(posedge clk); @(negedge clk);
    checks += 2;
    if (an_n !== 8'hFE)       begin errors++; $display("FAIL tick0_an got=%h want=fe", an_n); end
    if (seg_n !== 7'b0000001) begin errors++; $display("FAIL tick0_seg got=%b want=0000001", seg_n); end
    bus_cycle(1'b0, 2'd0, 32'd0, 4'h0, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL rst_data_rd got=%h want=0", rd); end
    bus_cycle(1'b0, 2'd1, 32'd0, 4'h0, rd);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL rst_ctrl_rd got=%h want=1", rd); end
    // read commits on edge n=9, after ticks at n=4 and n=8
    bus_cycle(1'b0, 2'd2, 32'd0, 4'h0, rd);
    checks++;
    if (rd !== 32'd2) begin errors++; $display("FAIL status_rd got=%h want=2", rd); end
    wait_tick();
    checks++;
    if (an_n !== ~(8'h01 << tick_idx)) begin
      errors++; $display("FAIL tick_an idx=%0d got=%h", tick_idx, an_n);
    end
  endtask

  task automatic test_hex();
    logic [31:0] rd;
    logic [31:0] val;
    logic [6:0]  es;
    bus_cycle(1'b1, 2'd0, 32'hDEAD_BEA5, 4'h1, rd);
    bus_cycle(1'b0, 2'd0, 32'd0, 4'h0, rd);
    checks++;
    if (rd !== 32'h0000_00A5) begin errors++; $display("FAIL data_sel_rd got=%h want=000000a5", rd); end
    bus_cycle(1'b1, 2'd1, 32'h3, 4'hF, rd);
    bus_cycle(1'b0, 2'd1, 32'd0, 4'h0, rd);
    checks++;
    if (rd !== 32'h3) begin errors++; $display("FAIL ctrl_rd got=%h want=3", rd); end
    for (int t = 0; t < ND; t++) begin
      wait_tick();
      es = (tick_idx == 0) ? 7'b0100100 : (tick_idx == 1) ? 7'b0001000 : 7'b0000001;
      checks += 2;
      if (an_n !== ~(8'h01 << tick_idx)) begin errors++; $display("FAIL hexa5_an idx=%0d got=%h", tick_idx, an_n); end
      if (seg_n !== es) begin errors++; $display("FAIL hexa5_seg idx=%0d got=%b want=%b", tick_idx, seg_n, es); end
    end
    val = 32'h89AB_CDEF;
    bus_cycle(1'b1, 2'd0, val, 4'hF, rd);
    for (int t = 0; t < ND; t++) begin
      wait_tick();
      es = hex_tab[(val >> (4 * tick_idx)) & 32'hF];
      checks++;
      if (seg_n !== es) begin errors++; $display("FAIL hexall_seg idx=%0d got=%b want=%b", tick_idx, seg_n, es); end
    end
  endtask

  task automatic test_binary_blank();
    logic [31:0] rd;
    logic [6:0]  es;
    logic [7:0]  ea;
    logic [31:0] val;
    val = 32'h0000_00A5;
    bus_cycle(1'b1, 2'd1, 32'h1, 4'hF, rd);
    bus_cycle(1'b1, 2'd0, val, 4'hF, rd);
    for (int t = 0; t < ND; t++) begin
      wait_tick();
      es = val[tick_idx] ? 7'b1001111 : 7'b0000001;
      checks++;
      if (seg_n !== es) begin errors++; $display("FAIL bin_seg idx=%0d got=%b want=%b", tick_idx, seg_n, es); end
    end
    bus_cycle(1'b1, 2'd1, 32'h0000_0201, 4'hF, rd);
    for (int t = 0; t < ND; t++) begin
      wait_tick();
      if (tick_idx == 1) begin ea = 8'hFF; es = 7'h7F; end
      else begin ea = ~(8'h01 << tick_idx); es = val[tick_idx] ? 7'b1001111 : 7'b0000001; end
      checks += 2;
      if (an_n !== ea) begin errors++; $display("FAIL blank_an idx=%0d got=%h want=%h", tick_idx, an_n, ea); end
      if (seg_n !== es) begin errors++; $display("FAIL blank_seg idx=%0d got=%b want=%b", tick_idx, seg_n, es); end
    end
    bus_cycle(1'b1, 2'd1, 32'h0, 4'hF, rd);
    for (int t = 0; t < 2; t++) begin
      wait_tick();
      checks += 2;
      if (an_n !== 8'hFF) begin errors++; $display("FAIL disable_an got=%h want=ff", an_n); end
      if (seg_n !== 7'h7F) begin errors++; $display("FAIL disable_seg got=%h want=7f", seg_n); end
    end
    bus_cycle(1'b1, 2'd1, 32'hFFFF_FFFF, 4'hF, rd);
    bus_cycle(1'b0, 2'd1, 32'd0, 4'h0, rd);
    checks++;
`ifdef SEG7_DP_EN
    if (rd !== 32'h00FF_FF03) begin errors++; $display("FAIL ctrl_mask_rd got=%h want=00ffff03", rd); end
`else
    if (rd !== 32'h0000_FF03) begin errors++; $display("FAIL ctrl_mask_rd got=%h want=0000ff03", rd); end
`endif
    bus_cycle(1'b1, 2'd3, 32'hFFFF_FFFF, 4'hF, rd);
    bus_cycle(1'b0, 2'd3, 32'd0, 4'h0, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL reg_c_rd got=%h want=0", rd); end
    bus_cycle(1'b1, 2'd1, 32'h1, 4'hF, rd);
  endtask

  task automatic test_back_to_back();
    logic exp_ack;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'd0; sel = 4'h0;
    for (int i = 0; i < 6; i++) begin
      exp_ack = (i % 2 == 1);
      checks++;
      if (ack !== exp_ack) begin errors++; $display("FAIL b2b_ack cycle=%0d got=%b want=%b", i, ack, exp_ack); end
      if (exp_ack) begin
        checks++;
        if (dat_o !== 32'h0000_00A5) begin errors++; $display("FAIL b2b_dat got=%h want=000000a5", dat_o); end
      end
      @(posedge clk); @(negedge clk);
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_write_on_tick();
    logic [31:0] rd;
    bus_cycle(1'b1, 2'd0, 32'd0, 4'hF, rd);
    for (int t = 0; t < 2 * ND; t++) begin
      wait_tick();
      if (tick_idx == ND - 1) break;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'd0; dat_i = 32'h0000_00FF; sel = 4'hF;
    @(posedge clk); @(negedge clk);
    checks += 3;
    if (ack !== 1'b1)         begin errors++; $display("FAIL wtick_ack got=%b want=1", ack); end
    if (an_n !== 8'hFE)       begin errors++; $display("FAIL wtick_an got=%h want=fe", an_n); end
    if (seg_n !== 7'b0000001) begin errors++; $display("FAIL wtick_old_seg got=%b want=0000001", seg_n); end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    wait_tick();
    checks++;
    if (seg_n !== 7'b1001111) begin errors++; $display("FAIL wtick_d1_seg got=%b want=1001111", seg_n); end
    for (int t = 0; t < ND; t++) begin
      wait_tick();
      if (tick_idx == 0) break;
    end
    checks += 2;
    if (an_n !== 8'hFE)       begin errors++; $display("FAIL wtick_pass2_an got=%h want=fe", an_n); end
    if (seg_n !== 7'b1001111) begin errors++; $display("FAIL wtick_pass2_seg got=%b want=1001111", seg_n); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'd0; dat_i = 32'h1; sel = 4'hF;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    checks += 2;
    if (ack !== 1'b0)   begin errors++; $display("FAIL rstmid_ack got=%b want=0", ack); end
    if (an_n !== 8'hFF) begin errors++; $display("FAIL rstmid_an got=%h want=ff", an_n); end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst = 1'b0;
    bus_cycle(1'b0, 2'd0, 32'd0, 4'h0, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL rstmid_data got=%h want=0", rd); end
    @(posedge clk); @(negedge clk);
    checks++;
    if (an_n !== 8'hFF) begin errors++; $display("FAIL rstmid_early_an got=%h want=ff", an_n); end
    @(posedge clk); @(negedge clk);
    checks += 2;
    if (an_n !== 8'hFE)       begin errors++; $display("FAIL rstmid_tick_an got=%h want=fe", an_n); end
    if (seg_n !== 7'b0000001) begin errors++; $display("FAIL rstmid_tick_seg got=%b want=0000001", seg_n); end
  endtask

  initial begin
    test_reset();
    test_hex();
    test_binary_blank();
    test_back_to_back();
    test_write_on_tick();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
